handshake_reg_slice: RTL and testbench

//  Parametrised valid/ready register slice. Provides forward-registered, backward-registered
//  or fully-registered (skid) mode, chained over STAGES stages, plus sync flush and occupancy.

---
 rtl/handshake_reg_slice.sv | 158 +++++++++++++++
 tb/tb_handshake_reg_slice.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_reg_slice.sv
// Chained valid/ready register slice: forward-registered (MODE 0), backward/skid (MODE 1)
// or fully registered main+skid (MODE 2), with synchronous flush and registered occupancy.
module handshake_reg_slice #(
    parameter int WIDTH  = 8,
    parameter int MODE   = 2,
    parameter int STAGES = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          src_vaild,
    input  logic [WIDTH-1:0]              src_data_in,
    output logic                          src_ready,
    output logic                          dst_vaild,
    output logic [WIDTH-1:0]              dst_data_out,
    input  logic                          dst_ready,
    output logic [$clog2(2*STAGES+1)-1:0] occupancy
);
    localparam int OW = $clog2(2*STAGES+1);

    // Handshake: a beat crosses a boundary at a rising clk edge where valid and ready are
    // both high; a presented beat keeps its valid and data until that edge.
    logic             vld_c [STAGES+1];
    logic             rdy_c [STAGES+1];
    logic [WIDTH-1:0] dat_c [STAGES+1];
    logic [1:0]       cnt_n [STAGES];
    logic [OW-1:0]    occ_n;
    logic [OW-1:0]    occ_q;

    generate
        if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
            $error("handshake_reg_slice: STAGES must be within 1..8");
        end
        if (MODE < 0 || MODE > 2) begin : g_bad_mode
            $error("handshake_reg_slice: MODE must be 0, 1 or 2");
        end
    endgenerate

    // Flush blocks both outer handshakes for its cycle; stages clear their flags internally.
    assign vld_c[0]      = src_vaild;
    assign dat_c[0]      = src_data_in;
    assign rdy_c[STAGES] = dst_ready & ~flush;
    assign src_ready     = rdy_c[0] & ~flush;
    assign dst_vaild     = vld_c[STAGES] & ~flush;
    assign dst_data_out  = dat_c[STAGES];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (MODE == 0) begin : g_fwd
            logic             vld_q;
            logic [WIDTH-1:0] dat_q;
            logic             rdy;

            assign rdy        = rdy_c[g+1] | ~vld_q;
            assign rdy_c[g]   = rdy;
            assign vld_c[g+1] = vld_q;
            assign dat_c[g+1] = dat_q;
            assign cnt_n[g]   = flush ? 2'd0 : {1'b0, (rdy ? vld_c[g] : vld_q)};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= 1'b0;
                    dat_q <= '0;
                end else if (flush) begin
                    vld_q <= 1'b0;
                end else if (rdy) begin
                    vld_q <= vld_c[g];
                    dat_q <= dat_c[g];
                end
            end
        end else if (MODE == 1) begin : g_bwd
            logic             skid_vld;
            logic [WIDTH-1:0] skid_dat;
            logic             skid_vld_n;

            assign rdy_c[g]   = ~skid_vld;
            assign vld_c[g+1] = vld_c[g] | skid_vld;
            assign dat_c[g+1] = skid_vld ? skid_dat : dat_c[g];
            assign skid_vld_n = rdy_c[g+1] ? 1'b0 : (skid_vld | vld_c[g]);
            assign cnt_n[g]   = flush ? 2'd0 : {1'b0, skid_vld_n};

            // The skid only captures a beat that was accepted but could not pass downstream.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    skid_vld <= 1'b0;
                    skid_dat <= '0;
                end else if (flush) begin
                    skid_vld <= 1'b0;
                end else begin
                    skid_vld <= skid_vld_n;
                    if (vld_c[g] && !skid_vld && !rdy_c[g+1]) begin
                        skid_dat <= dat_c[g];
                    end
                end
            end
        end else begin : g_full
            logic             main_vld;
            logic             skid_vld;
            logic [WIDTH-1:0] main_dat;
            logic [WIDTH-1:0] skid_dat;
            logic             drain;
            logic             accept;
            logic             main_vld_n;
            logic             skid_vld_n;

            assign drain      = ~main_vld | rdy_c[g+1];
            assign accept     = vld_c[g] & ~skid_vld;
            assign main_vld_n = drain ? (skid_vld | accept) : 1'b1;
            assign skid_vld_n = drain ? 1'b0 : (skid_vld | accept);
            assign rdy_c[g]   = ~skid_vld;
            assign vld_c[g+1] = main_vld;
            assign dat_c[g+1] = main_dat;
            assign cnt_n[g]   = flush ? 2'd0 : ({1'b0, main_vld_n} + {1'b0, skid_vld_n});

            // Skid has priority into main so the older beat always leaves first.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_vld <= 1'b0;
                    skid_vld <= 1'b0;
                    main_dat <= '0;
                    skid_dat <= '0;
                end else if (flush) begin
                    main_vld <= 1'b0;
                    skid_vld <= 1'b0;
                end else begin
                    main_vld <= main_vld_n;
                    skid_vld <= skid_vld_n;
                    if (drain) begin
                        if (skid_vld) begin
                            main_dat <= skid_dat;
                        end else if (accept) begin
                            main_dat <= dat_c[g];
                        end
                    end else if (accept) begin
                        skid_dat <= dat_c[g];
                    end
                end
            end
        end
    end

    always_comb begin
        occ_n = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_n = occ_n + OW'(cnt_n[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_n;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_handshake_reg_slice.sv
// Bench for handshake_reg_slice: four configurations (M2S1, M2S2, M0S3, M1S1) exercised by
// directed scenarios and a randomized stream checked against an in-order beat queue.
module tb_handshake_reg_slice;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       src_v [4];
    logic [7:0] src_d [4];
    logic       src_r [4];
    logic       dst_v [4];
    logic [7:0] dst_d [4];
    logic       dst_r [4];
    logic       flush [4];
    logic [1:0] occ0;
    logic [2:0] occ1;
    logic [2:0] occ2;
    logic [1:0] occ3;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    handshake_reg_slice #(.WIDTH(8), .MODE(2), .STAGES(1)) u_m2s1 (
        .clk(clk), .rst_n(rst_n), .flush(flush[0]),
        .src_vaild(src_v[0]), .src_data_in(src_d[0]), .src_ready(src_r[0]),
        .dst_vaild(dst_v[0]), .dst_data_out(dst_d[0]), .dst_ready(dst_r[0]),
        .occupancy(occ0)
    );
    handshake_reg_slice #(.WIDTH(8), .MODE(2), .STAGES(2)) u_m2s2 (
        .clk(clk), .rst_n(rst_n), .flush(flush[1]),
        .src_vaild(src_v[1]), .src_data_in(src_d[1]), .src_ready(src_r[1]),
        .dst_vaild(dst_v[1]), .dst_data_out(dst_d[1]), .dst_ready(dst_r[1]),
        .occupancy(occ1)
    );
    handshake_reg_slice #(.WIDTH(8), .MODE(0), .STAGES(3)) u_m0s3 (
        .clk(clk), .rst_n(rst_n), .flush(flush[2]),
        .src_vaild(src_v[2]), .src_data_in(src_d[2]), .src_ready(src_r[2]),
        .dst_vaild(dst_v[2]), .dst_data_out(dst_d[2]), .dst_ready(dst_r[2]),
        .occupancy(occ2)
    );
    handshake_reg_slice #(.WIDTH(8), .MODE(1), .STAGES(1)) u_m1s1 (
        .clk(clk), .rst_n(rst_n), .flush(flush[3]),
        .src_vaild(src_v[3]), .src_data_in(src_d[3]), .src_ready(src_r[3]),
        .dst_vaild(dst_v[3]), .dst_data_out(dst_d[3]), .dst_ready(dst_r[3]),
        .occupancy(occ3)
    );

    function automatic int occ_of(input int d);
        case (d)
            0:       return int'(occ0);
            1:       return int'(occ1);
            2:       return int'(occ2);
            default: return int'(occ3);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d);
        src_v[d] = 1'b0;
        src_d[d] = 8'h00;
        dst_r[d] = 1'b0;
        flush[d] = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (dst_v[i] !== 1'b0) begin n_err++; $display("FAIL reset_dst_v[%0d]: got %b want 0", i, dst_v[i]); end
            n_cmp++; if (dst_d[i] !== 8'h00) begin n_err++; $display("FAIL reset_dst_d[%0d]: got %h want 00", i, dst_d[i]); end
            n_cmp++; if (occ_of(i) != 0) begin n_err++; $display("FAIL reset_occ[%0d]: got %0d want 0", i, occ_of(i)); end
            n_cmp++; if (src_r[i] !== 1'b1) begin n_err++; $display("FAIL reset_src_r[%0d]: got %b want 1", i, src_r[i]); end
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
    endtask

    // MODE 2, one stage: 0x01..0x10 at full rate, one-cycle latency, src_ready never drops.
    task automatic test_stream_full();
        bit exp_v;
        for (int c = 0; c < 18; c++) begin
            src_v[0] = (c < 16);
            src_d[0] = 8'(c + 1);
            dst_r[0] = 1'b1;
            @(negedge clk);
            exp_v = (c >= 1 && c <= 16);
            if (c < 16) begin
                n_cmp++; if (src_r[0] !== 1'b1) begin n_err++; $display("FAIL stream_src_r c%0d: got %b want 1", c, src_r[0]); end
            end
            n_cmp++; if (dst_v[0] !== exp_v) begin n_err++; $display("FAIL stream_dst_v c%0d: got %b want %b", c, dst_v[0], exp_v); end
            if (exp_v) begin
                n_cmp++; if (dst_d[0] !== 8'(c)) begin n_err++; $display("FAIL stream_dst_d c%0d: got %h want %h", c, dst_d[0], 8'(c)); end
            end
            step();
        end
        idle(0);
        step();
    endtask

    // MODE 2, one stage: sink stalls after two beats, then releases; order preserved.
    task automatic test_backpressure_full();
        logic [7:0] exp_q[$];
        logic [7:0] nxt;
        logic [7:0] want;
        int         dlv;
        src_v[0] = 1'b1; src_d[0] = 8'h01; dst_r[0] = 1'b0;
        @(negedge clk);
        n_cmp++; if (src_r[0] !== 1'b1) begin n_err++; $display("FAIL bp_ready_b1: got %b want 1", src_r[0]); end
        step();
        src_d[0] = 8'h02;
        @(negedge clk);
        n_cmp++; if (src_r[0] !== 1'b1) begin n_err++; $display("FAIL bp_ready_b2: got %b want 1", src_r[0]); end
        step();
        src_d[0] = 8'h03;
        @(negedge clk);
        n_cmp++; if (occ0 !== 2'd2) begin n_err++; $display("FAIL bp_occ: got %0d want 2", occ0); end
        n_cmp++; if (src_r[0] !== 1'b0) begin n_err++; $display("FAIL bp_ready_full: got %b want 0", src_r[0]); end
        n_cmp++; if (dst_v[0] !== 1'b1 || dst_d[0] !== 8'h01) begin n_err++; $display("FAIL bp_head: got v=%b d=%h want v=1 d=01", dst_v[0], dst_d[0]); end
        step();
        exp_q = '{8'h01, 8'h02};
        nxt = 8'h03;
        dlv = 0;
        dst_r[0] = 1'b1;
        for (int c = 0; c < 40 && dlv < 8; c++) begin
            @(negedge clk);
            if (src_v[0] && src_r[0]) begin
                exp_q.push_back(src_d[0]);
                nxt = nxt + 8'd1;
            end
            if (dst_v[0] && dst_r[0]) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                n_cmp++; if (dst_d[0] !== want) begin n_err++; $display("FAIL bp_order: got %h want %h", dst_d[0], want); end
                dlv++;
            end
            step();
            src_v[0] = (nxt <= 8'h08);
            src_d[0] = nxt;
        end
        n_cmp++; if (dlv != 8) begin n_err++; $display("FAIL bp_count: got %0d beats want 8", dlv); end
        idle(0);
        step();
    endtask

    // MODE 0, three stages: 3-cycle latency, combinational src_ready drop, drain in order.
    task automatic test_forward_chain();
        int ev [13] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        int ed [13] = '{0, 0, 0, 1, 2, 3, 4, 4, 4, 5, 6, 7, 0};
        int eo [13] = '{0, 1, 2, 3, 3, 3, 3, 3, 3, 3, 2, 1, 0};
        int er [13] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        for (int c = 0; c < 13; c++) begin
            src_v[2] = (c <= 8);
            src_d[2] = (c < 6) ? 8'(c + 1) : 8'h07;
            dst_r[2] = !(c == 6 || c == 7);
            @(negedge clk);
            n_cmp++; if (dst_v[2] !== ev[c][0]) begin n_err++; $display("FAIL fwd_dst_v c%0d: got %b want %0d", c, dst_v[2], ev[c]); end
            if (ev[c] == 1) begin
                n_cmp++; if (dst_d[2] !== 8'(ed[c])) begin n_err++; $display("FAIL fwd_dst_d c%0d: got %h want %h", c, dst_d[2], 8'(ed[c])); end
            end
            n_cmp++; if (int'(occ2) != eo[c]) begin n_err++; $display("FAIL fwd_occ c%0d: got %0d want %0d", c, occ2, eo[c]); end
            n_cmp++; if (src_r[2] !== er[c][0]) begin n_err++; $display("FAIL fwd_src_r c%0d: got %b want %0d", c, src_r[2], er[c]); end
            step();
        end
        idle(2);
        step();
    endtask

    // MODE 1: 0xA5 appears with zero latency, skid holds it while stalled, then 0xA6 follows.
    task automatic test_backward_skid();
        int         sv [5] = '{1, 1, 1, 1, 0};
        logic [7:0] sd [5] = '{8'hA5, 8'hA6, 8'hA6, 8'hA6, 8'h00};
        int         dr [5] = '{0, 0, 1, 1, 1};
        int         ev [5] = '{1, 1, 1, 1, 0};
        logic [7:0] ed [5] = '{8'hA5, 8'hA5, 8'hA5, 8'hA6, 8'h00};
        int         eo [5] = '{0, 1, 1, 0, 0};
        int         er [5] = '{1, 0, 0, 1, 1};
        for (int c = 0; c < 5; c++) begin
            src_v[3] = sv[c][0];
            src_d[3] = sd[c];
            dst_r[3] = dr[c][0];
            @(negedge clk);
            n_cmp++; if (dst_v[3] !== ev[c][0]) begin n_err++; $display("FAIL bwd_dst_v c%0d: got %b want %0d", c, dst_v[3], ev[c]); end
            if (ev[c] == 1) begin
                n_cmp++; if (dst_d[3] !== ed[c]) begin n_err++; $display("FAIL bwd_dst_d c%0d: got %h want %h", c, dst_d[3], ed[c]); end
            end
            n_cmp++; if (int'(occ3) != eo[c]) begin n_err++; $display("FAIL bwd_occ c%0d: got %0d want %0d", c, occ3, eo[c]); end
            n_cmp++; if (src_r[3] !== er[c][0]) begin n_err++; $display("FAIL bwd_src_r c%0d: got %b want %0d", c, src_r[3], er[c]); end
            step();
        end
        idle(3);
        step();
    endtask

    // MODE 2, two stages: fill to 4, flush overrides live handshakes, slice is usable afterwards.
    task automatic test_flush();
        int acc_n = 0;
        bit acc;
        src_v[1] = 1'b1; src_d[1] = 8'h40; dst_r[1] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            acc = src_r[1];
            if (acc) acc_n++;
            step();
            if (acc) src_d[1] = src_d[1] + 8'd1;
        end
        @(negedge clk);
        n_cmp++; if (occ1 !== 3'd4) begin n_err++; $display("FAIL flush_fill_occ: got %0d want 4", occ1); end
        n_cmp++; if (src_r[1] !== 1'b0) begin n_err++; $display("FAIL flush_fill_ready: got %b want 0", src_r[1]); end
        n_cmp++; if (acc_n != 4) begin n_err++; $display("FAIL flush_fill_count: got %0d want 4", acc_n); end
        step();
        flush[1] = 1'b1; dst_r[1] = 1'b1;
        @(negedge clk);
        n_cmp++; if (src_r[1] !== 1'b0 || dst_v[1] !== 1'b0) begin n_err++; $display("FAIL flush_block: got src_r=%b dst_v=%b want 0 0", src_r[1], dst_v[1]); end
        step();
        flush[1] = 1'b0; src_v[1] = 1'b0; dst_r[1] = 1'b0;
        @(negedge clk);
        n_cmp++; if (occ1 !== 3'd0) begin n_err++; $display("FAIL flush_occ: got %0d want 0", occ1); end
        n_cmp++; if (dst_v[1] !== 1'b0) begin n_err++; $display("FAIL flush_dst_v: got %b want 0", dst_v[1]); end
        n_cmp++; if (src_r[1] !== 1'b1) begin n_err++; $display("FAIL flush_src_r: got %b want 1", src_r[1]); end
        step();
        src_v[1] = 1'b1; src_d[1] = 8'h55; dst_r[1] = 1'b1;
        @(negedge clk);
        n_cmp++; if (src_r[1] !== 1'b1) begin n_err++; $display("FAIL post_flush_ready: got %b want 1", src_r[1]); end
        step();
        src_v[1] = 1'b0;
        @(negedge clk);
        n_cmp++; if (dst_v[1] !== 1'b0) begin n_err++; $display("FAIL post_flush_early: got %b want 0", dst_v[1]); end
        step();
        @(negedge clk);
        n_cmp++; if (dst_v[1] !== 1'b1 || dst_d[1] !== 8'h55) begin n_err++; $display("FAIL post_flush_beat: got v=%b d=%h want v=1 d=55", dst_v[1], dst_d[1]); end
        step();
        idle(1);
        step();
    endtask

    // Random source/sink/flush; the model is the queue of accepted, undelivered beats.
    task automatic test_random(input int d, input int cap, input int cycles);
        logic [7:0] exp_q[$];
        logic [7:0] want;
        logic [7:0] held_d;
        bit         held;
        bit         acc;
        int         occ_v;
        held = 1'b0;
        held_d = 8'h00;
        src_v[d] = 1'b0; src_d[d] = 8'($urandom); dst_r[d] = 1'b0; flush[d] = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            occ_v = occ_of(d);
            n_cmp++; if (occ_v != exp_q.size()) begin n_err++; $display("FAIL rnd%0d_occ c%0d: got %0d want %0d", d, c, occ_v, exp_q.size()); end
            n_cmp++; if (occ_v > cap) begin n_err++; $display("FAIL rnd%0d_cap c%0d: got %0d want <= %0d", d, c, occ_v, cap); end
            acc = 1'b0;
            if (flush[d]) begin
                n_cmp++; if (src_r[d] !== 1'b0 || dst_v[d] !== 1'b0) begin n_err++; $display("FAIL rnd%0d_flush c%0d: got src_r=%b dst_v=%b want 0 0", d, c, src_r[d], dst_v[d]); end
                exp_q.delete();
                held = 1'b0;
            end else begin
                if (held) begin
                    n_cmp++; if (dst_v[d] !== 1'b1 || dst_d[d] !== held_d) begin n_err++; $display("FAIL rnd%0d_stable c%0d: got v=%b d=%h want v=1 d=%h", d, c, dst_v[d], dst_d[d], held_d); end
                end
                acc = src_v[d] && src_r[d];
                if (acc) exp_q.push_back(src_d[d]);
                if (dst_v[d] && dst_r[d]) begin
                    want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    n_cmp++; if (dst_d[d] !== want) begin n_err++; $display("FAIL rnd%0d_data c%0d: got %h want %h", d, c, dst_d[d], want); end
                end
                held = dst_v[d] && !dst_r[d];
                held_d = dst_d[d];
            end
            step();
            if (!(src_v[d] && !acc)) begin
                src_v[d] = ($urandom_range(0, 3) != 0);
                src_d[d] = 8'($urandom);
            end
            dst_r[d] = ((c % 64) < 16) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
            flush[d] = ($urandom_range(0, 39) == 0);
        end
        src_v[d] = 1'b0; dst_r[d] = 1'b1; flush[d] = 1'b0;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (dst_v[d]) begin
                want = exp_q.pop_front();
                n_cmp++; if (dst_d[d] !== want) begin n_err++; $display("FAIL rnd%0d_drain: got %h want %h", d, dst_d[d], want); end
            end
            step();
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rnd%0d_drain_left: got %0d beats left want 0", d, exp_q.size()); end
        idle(d);
        step();
    endtask

    // Async reset mid-stream clears everything at once; a fresh stream then passes intact.
    task automatic test_async_reset();
        logic [7:0] exp_q[$];
        logic [7:0] nxt;
        logic [7:0] want;
        int         dlv;
        bit         acc;
        for (int i = 0; i < 4; i++) idle(i);
        step();
        src_v[0] = 1'b1; src_d[0] = 8'h70;
        step();
        src_d[0] = 8'h71;
        step();
        src_d[0] = 8'h72;
        step();
        n_cmp++; if (occ0 !== 2'd2) begin n_err++; $display("FAIL arst_pre_occ: got %0d want 2", occ0); end
        #2 rst_n = 1'b0;
        #1;
        src_v[0] = 1'b0; src_d[0] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (dst_v[i] !== 1'b0) begin n_err++; $display("FAIL arst_dst_v[%0d]: got %b want 0", i, dst_v[i]); end
            n_cmp++; if (dst_d[i] !== 8'h00) begin n_err++; $display("FAIL arst_dst_d[%0d]: got %h want 00", i, dst_d[i]); end
            n_cmp++; if (occ_of(i) != 0) begin n_err++; $display("FAIL arst_occ[%0d]: got %0d want 0", i, occ_of(i)); end
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        nxt = 8'h10;
        dlv = 0;
        src_v[0] = 1'b1; src_d[0] = nxt; dst_r[0] = 1'($urandom_range(0, 1));
        for (int c = 0; c < 120 && dlv < 16; c++) begin
            @(negedge clk);
            acc = src_v[0] && src_r[0];
            if (acc) begin
                exp_q.push_back(src_d[0]);
                nxt = nxt + 8'd1;
            end
            if (dst_v[0] && dst_r[0]) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                n_cmp++; if (dst_d[0] !== want) begin n_err++; $display("FAIL arst_stream: got %h want %h", dst_d[0], want); end
                dlv++;
            end
            step();
            if (acc) begin
                src_v[0] = (nxt <= 8'h1F);
                src_d[0] = nxt;
            end
            dst_r[0] = ($urandom_range(0, 2) != 0);
        end
        n_cmp++; if (dlv != 16) begin n_err++; $display("FAIL arst_count: got %0d beats want 16", dlv); end
        idle(0);
        step();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) idle(i);
        test_reset();
        test_stream_full();
        test_backpressure_full();
        test_forward_chain();
        test_backward_skid();
        test_flush();
        test_random(0, 2, 300);
        test_random(1, 4, 300);
        test_random(2, 3, 300);
        test_random(3, 1, 300);
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
